// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a synchronous FIFO, with optional locked bursts,
// full/almostfull write gating and per-write acknowledge checking.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic                          busy,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic                          drop_err
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int BC_W  = $clog2(MAX_BURST + 1);

  typedef enum logic {ARB, OWN} state_t;

  state_t                 state_reg, state_next;
  logic [PTR_W-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0]       owner_reg, owner_next;
  logic [BC_W-1:0]        burst_cnt_reg, burst_cnt_next;
  logic                   ack_pend_reg;

  logic                   space;
  logic                   rr_found;
  logic [PTR_W-1:0]       rr_win;
  logic [PTR_W-1:0]       scan_idx;
  logic                   grant_any;
  logic [PTR_W-1:0]       winner;
  logic [FIFO_WIDTH-1:0]  words [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
      assign words[gi] = req_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
    end
  endgenerate

  // Pointer increment that wraps at NUM_REQ-1, so non power-of-two counts work.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // The write already in flight may consume the last free slot.
  assign space = !fifo_full && !(fifo_almostfull && fifo_wr_en);

  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    scan_idx = rr_ptr_reg;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!rr_found && req[scan_idx]) begin
        rr_found = 1'b1;
        rr_win   = scan_idx;
      end
      scan_idx = wrap_inc(scan_idx);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ARB;
      rr_ptr_reg    <= '0;
      owner_reg     <= '0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      owner_reg     <= owner_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  // Output logic: who, if anyone, is granted this cycle
  always_comb begin
    grant_any = 1'b0;
    winner    = rr_win;
    gnt       = '0;
    if (state_reg == OWN) begin
      winner    = owner_reg;
      grant_any = req[owner_reg] && space;
    end else begin
      grant_any = rr_found && space;
    end
    if (rst_n && grant_any) gnt[winner] = 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    owner_next     = owner_reg;
    burst_cnt_next = burst_cnt_reg;
    case (state_reg)
      ARB: begin
        if (grant_any) begin
          rr_ptr_next = wrap_inc(winner);
          if (lock[winner] && (MAX_BURST > 1)) begin
            state_next     = OWN;
            owner_next     = winner;
            burst_cnt_next = BC_W'(1);
          end
        end
      end
      OWN: begin
        if (grant_any) begin
          burst_cnt_next = burst_cnt_reg + BC_W'(1);
          rr_ptr_next    = wrap_inc(owner_reg);
          if (!lock[owner_reg] || (burst_cnt_next == BC_W'(MAX_BURST))) state_next = ARB;
        end else if (!req[owner_reg]) begin
          state_next = ARB;
        end
      end
      default: state_next = ARB;
    endcase
  end

  // Write stage and acknowledge checking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      ack_pend_reg <= 1'b0;
      drop_cnt     <= '0;
      drop_err     <= 1'b0;
    end else begin
      fifo_wr_en   <= grant_any;
      if (grant_any) fifo_data_in <= words[winner];
      ack_pend_reg <= fifo_wr_en;
      if (ack_pend_reg && (fifo_overflow || !fifo_wr_ack)) begin
        drop_err <= 1'b1;
        if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  assign busy = (state_reg == OWN) || fifo_wr_en || ack_pend_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: a queue-level FIFO model plus a behavioural
// arbitration model, compared against the DUT every cycle, with directed literal checks.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int MB    = 4;
  localparam int CW    = 8;
  localparam int DEPTH = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, lock, gnt;
  logic [N*W-1:0] req_data;
  logic           fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
  logic           fifo_wr_en, busy, drop_err;
  logic [W-1:0]   fifo_data_in;
  logic [CW-1:0]  drop_cnt;

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MB), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .req_data(req_data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull), .fifo_wr_ack(fifo_wr_ack),
    .fifo_overflow(fifo_overflow), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .busy(busy), .drop_cnt(drop_cnt), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Requester stimulus state
  logic [N-1:0] req_b, lock_b;
  logic [W-1:0] dw [N];
  bit           auto_req;

  // FIFO model
  int   fcount;
  bit   f_ack, f_ovf;
  int   rd_pct, inj_permil;
  bit   force_rd;

  // Arbiter model
  int           rr, owner, bcnt;
  bit           own;
  bit           wr_en_m, ack_pend_m, err_m;
  logic [W-1:0] data_m;
  int           drop_m;

  logic [N-1:0] last_gnt;
  int           wr_tally, gnt_tally;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_inputs();
    req  = req_b;
    lock = lock_b;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = dw[i];
    fifo_full       = (fcount == DEPTH);
    fifo_almostfull = (fcount == DEPTH - 1);
    fifo_wr_ack     = f_ack;
    fifo_overflow   = f_ovf;
  endtask

  task automatic model_reset();
    rr = 0; owner = 0; bcnt = 0; own = 0;
    wr_en_m = 0; ack_pend_m = 0; err_m = 0; data_m = '0; drop_m = 0;
    fcount = 0; f_ack = 0; f_ovf = 0; force_rd = 0;
  endtask

  // Which requester the rules say is accepted with the current inputs.
  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g = '0;
    bit sp = !fifo_full && !(fifo_almostfull && wr_en_m);
    if (!rst_n || !sp) return g;
    if (own) begin
      if (req[owner]) g[owner] = 1'b1;
      return g;
    end
    for (int k = 0; k < N; k++) begin
      int i = (rr + k) % N;
      if (req[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_step(input logic [N-1:0] eg);
    int  win = -1;
    bit  n_ack = 0, n_ovf = 0;
    for (int i = 0; i < N; i++) if (eg[i]) win = i;
    if (ack_pend_m && (f_ovf || !f_ack)) begin
      if (drop_m < (1 << CW) - 1) drop_m++;
      err_m = 1;
    end
    ack_pend_m = wr_en_m;
    if (wr_en_m) begin
      if (fcount < DEPTH && !(int'($urandom_range(0, 999)) < inj_permil)) begin
        fcount++;
        n_ack = 1;
      end else begin
        n_ovf = $urandom_range(0, 1) == 1;
      end
    end
    if (fcount > 0 && (force_rd || int'($urandom_range(0, 99)) < rd_pct)) fcount--;
    force_rd = 0;
    f_ack = n_ack;
    f_ovf = n_ovf;
    wr_en_m = (win >= 0);
    if (win >= 0) data_m = dw[win];
    if (!own) begin
      if (win >= 0) begin
        rr = (win + 1) % N;
        if (lock[win] && MB > 1) begin
          own = 1; owner = win; bcnt = 1;
        end
      end
    end else if (win >= 0) begin
      bcnt++;
      rr = (owner + 1) % N;
      if (!lock[owner] || bcnt == MB) own = 0;
    end else if (!req[owner]) begin
      own = 0;
    end
  endtask

  task automatic update_requesters(input logic [N-1:0] eg);
    for (int i = 0; i < N; i++) begin
      if (eg[i]) begin
        $display("t=%0t grant req=%0d data=%h", $time, i, dw[i]);
        dw[i] = W'($urandom);
        if (auto_req) begin
          req_b[i]  = $urandom_range(0, 99) < 70;
          lock_b[i] = $urandom_range(0, 3) == 0;
        end
      end else if (auto_req && !req_b[i]) begin
        req_b[i]  = $urandom_range(0, 99) < 30;
        lock_b[i] = $urandom_range(0, 3) == 0;
        dw[i]     = W'($urandom);
      end
    end
  endtask

  // One clock: compare at negedge, advance model at posedge, drive new inputs just after.
  task automatic cycle();
    logic [N-1:0] eg;
    @(negedge clk);
    eg = model_gnt();
    check("gnt", 32'(gnt), 32'(eg));
    check("wr_en", 32'(fifo_wr_en), 32'(wr_en_m));
    check("data_in", 32'(fifo_data_in), 32'(data_m));
    check("busy", 32'(busy), 32'(own || wr_en_m || ack_pend_m));
    check("drop_cnt", 32'(drop_cnt), 32'(drop_m));
    check("drop_err", 32'(drop_err), 32'(err_m));
    last_gnt = gnt;
    if (fifo_wr_en) wr_tally++;
    if (|gnt) gnt_tally++;
    @(posedge clk);
    if (rst_n) model_step(eg);
    #1;
    update_requesters(eg);
    apply_inputs();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    apply_inputs();
    repeat (n) cycle();
    rst_n = 1'b1;
  endtask

  logic [N-1:0] rr_seq [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
  logic [N-1:0] bu_seq [8] = '{4'h1, 4'h2, 4'h4, 4'h4, 4'h4, 4'h4, 4'h8, 4'h1};

  initial begin
    rst_n = 1'b0;
    req_b = '1; lock_b = '0; auto_req = 0;
    rd_pct = 100; inj_permil = 0;
    for (int i = 0; i < N; i++) dw[i] = W'($urandom);
    model_reset();
    apply_inputs();

    // Reset with all requesters asking
    do_reset(3);
    check("rst_gnt", 32'(last_gnt), 32'h0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'h0);

    // Round robin with FIFO drained every cycle
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("rr_seq", 32'(last_gnt), 32'(rr_seq[k]));
    end

    // Locked burst on requester 2
    lock_b[2] = 1'b1;
    apply_inputs();
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("burst_seq", 32'(last_gnt), 32'(bu_seq[k]));
    end
    repeat (3) cycle();

    // Reset pulse while requester 2 owns the port
    req_b = 4'b1100; lock_b = '0;
    do_reset(1);
    cycle();
    check("rst_own_gnt", 32'(last_gnt), 32'h4);

    // Fill an 8-deep FIFO with no reads from requester 0 only
    req_b = 4'b0001; rd_pct = 0;
    do_reset(2);
    wr_tally = 0;
    repeat (20) cycle();
    check("full_writes", 32'(wr_tally), 32'd8);
    force_rd = 1;
    gnt_tally = 0;
    repeat (6) cycle();
    check("full_rd_grants", 32'(gnt_tally), 32'd1);
    check("full_no_drop", 32'(drop_cnt), 32'h0);

    // Forced loss of one write
    rd_pct = 100;
    do_reset(1);
    cycle();
    inj_permil = 1000;
    cycle();
    inj_permil = 0;
    req_b = '0;
    apply_inputs();
    repeat (3) cycle();
    check("drop_cnt_one", 32'(drop_cnt), 32'h1);
    check("drop_err_set", 32'(drop_err), 32'h1);
    repeat (5) cycle();
    check("drop_err_sticky", 32'(drop_err), 32'h1);
    do_reset(1);
    check("drop_err_clr", 32'(drop_err), 32'h0);

    // Randomized traffic
    auto_req = 1; inj_permil = 5;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) rd_pct = $urandom_range(0, 100);
      if ($urandom_range(0, 499) == 0) do_reset(1);
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
